// File: rtl/mem_pkg.sv
// mem_pkg: definitions shared by the paged-memory writer and reader.
// Holds the derived-width helpers, the writer state encoding and the
// helper that locates one page's entry count in the packed nent vector.
package mem_pkg;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_CLEAR = 2'd1,
    WR_FILL  = 2'd2,
    WR_FULL  = 2'd3
  } wr_state_e;

  // Address bits needed to index one page.
  function automatic int calc_addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Count bits: one extra bit so a full page (== depth) is representable.
  function automatic int calc_nent_w(input int depth);
    return $clog2(depth) + 32'sd1;
  endfunction

  // Page-select bits; at least one even for a single page.
  function automatic int calc_page_w(input int pages);
    return (pages > 32'sd1) ? $clog2(pages) : 32'sd1;
  endfunction

  // Bit offset of page p's entry count inside the packed nent vector.
  function automatic int nent_lsb(input int page, input int nent_w);
    return page * nent_w;
  endfunction

endpackage

// File: rtl/mem_page_writer_if.sv
// mem_page_writer_if: incoming valid/ready word stream plus the BRAM
// port-A write bus. The writer uses the master view; whoever feeds the
// words and watches the BRAM side uses the slave view.
interface mem_page_writer_if
  import mem_pkg::*;
#(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 16,
  parameter int PAGES     = 2
);
  localparam int ADDR_W = calc_addr_w(RAM_DEPTH);
  localparam int PAGE_W = calc_page_w(PAGES);

  logic                 din_valid;
  logic [RAM_WIDTH-1:0] din_data;
  logic                 din_ready;
  logic                 wea;
  logic [ADDR_W-1:0]    addra;
  logic [PAGE_W-1:0]    pagea;
  logic [RAM_WIDTH-1:0] dina;

  modport master (
    input  din_valid, din_data,
    output din_ready, wea, addra, pagea, dina
  );

  modport slave (
    output din_valid, din_data,
    input  din_ready, wea, addra, pagea, dina
  );
endinterface

// File: rtl/mem_nent_counter.sv
// mem_nent_counter: per-page entry counts. A clear and an increment on
// the same page in the same cycle resolve to zero, so a freshly opened
// page never inherits a late write from its previous use.
module mem_nent_counter
  import mem_pkg::*;
#(
  parameter int RAM_DEPTH = 16,
  parameter int PAGES     = 2,
  localparam int NENT_W   = calc_nent_w(RAM_DEPTH),
  localparam int PAGE_W   = calc_page_w(PAGES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_en_i,
  input  logic [PAGE_W-1:0]       clr_page_i,
  input  logic                    inc_en_i,
  input  logic [PAGE_W-1:0]       inc_page_i,
  output logic [PAGES*NENT_W-1:0] nent_o
);

  logic [NENT_W-1:0] cnt_q [PAGES];
  logic [NENT_W-1:0] cnt_d [PAGES];

  // Next count per page: clear beats increment; increment stops at a full page.
  always_comb begin
    cnt_d = cnt_q;
    for (int p = 0; p < PAGES; p++) begin
      if (clr_en_i && (clr_page_i == PAGE_W'(p))) begin
        cnt_d[p] = {NENT_W{1'b0}};
      end else if (inc_en_i && (inc_page_i == PAGE_W'(p)) &&
                   (cnt_q[p] != NENT_W'(RAM_DEPTH))) begin
        cnt_d[p] = cnt_q[p] + NENT_W'(1'b1);
      end else begin
        cnt_d[p] = cnt_q[p];
      end
    end
  end

  // Count storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < PAGES; p++) cnt_q[p] <= {NENT_W{1'b0}};
    end else begin
      for (int p = 0; p < PAGES; p++) cnt_q[p] <= cnt_d[p];
    end
  end

  for (genvar g = 0; g < PAGES; g++) begin : g_pack
    assign nent_o[nent_lsb(g, NENT_W) +: NENT_W] = cnt_q[g];
  end

endmodule

// File: rtl/mem_page_writer.sv
// mem_page_writer: writes a valid/ready word stream sequentially into the
// page chosen by the current BX (page = bx mod PAGES) on BRAM port A and
// keeps a per-page entry count for the reader.
// Optional feature macro: MEM_WRITER_DROP_CNT_EN enables the saturating
// count of words refused while the page is full; otherwise dropped_cnt is 0.
module mem_page_writer
  import mem_pkg::*;
#(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 16,
  parameter int PAGES     = 2,
  parameter int BX_W      = 2,
  localparam int ADDR_W   = calc_addr_w(RAM_DEPTH),
  localparam int NENT_W   = calc_nent_w(RAM_DEPTH),
  localparam int PAGE_W   = calc_page_w(PAGES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BX_W-1:0]         bx_in,
  mem_page_writer_if.master       bus,
  output logic [PAGES*NENT_W-1:0] nent_o,
  output logic [BX_W-1:0]         bx_out,
  output logic [7:0]              dropped_cnt
);

  wr_state_e            state_q, state_d;
  logic [BX_W-1:0]      bx_q, bx_d;
  logic [PAGE_W-1:0]    page_q, page_d;
  logic [NENT_W-1:0]    wr_addr_q, wr_addr_d;  // reaches RAM_DEPTH when full
  logic                 wea_q, wea_d;
  logic [ADDR_W-1:0]    addra_q, addra_d;
  logic [PAGE_W-1:0]    pagea_q, pagea_d;
  logic [RAM_WIDTH-1:0] dina_q, dina_d;

  logic                 din_ready_s;
  logic                 clear_s;
  logic                 accept_s;
  logic                 bx_change_s;
  logic                 last_s;
  logic [PAGE_W-1:0]    page_in_s;

  assign page_in_s   = PAGE_W'(int'(bx_in) % PAGES);
  assign bx_change_s = (bx_in != bx_q);
  assign last_s      = (wr_addr_q == NENT_W'(RAM_DEPTH - 1));
  assign accept_s    = bus.din_valid & din_ready_s;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= WR_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: a BX change from FILL or FULL always reopens a page.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WR_IDLE:  state_d = WR_CLEAR;
      WR_CLEAR: state_d = WR_FILL;
      WR_FILL: begin
        if (bx_change_s)             state_d = WR_CLEAR;
        else if (accept_s && last_s) state_d = WR_FULL;
        else                         state_d = WR_FILL;
      end
      WR_FULL: begin
        if (bx_change_s) state_d = WR_CLEAR;
        else             state_d = WR_FULL;
      end
      default: state_d = WR_IDLE;
    endcase
  end

  // FSM outputs: ready only while filling and the BX is unchanged, so a
  // word offered on a BX-change cycle waits for the new page.
  always_comb begin
    din_ready_s = 1'b0;
    clear_s     = 1'b0;
    case (state_q)
      WR_CLEAR: clear_s     = 1'b1;
      WR_FILL:  din_ready_s = ~bx_change_s;
      default:  din_ready_s = 1'b0;
    endcase
  end

  // Datapath next values: page opening on clear, write capture on accept.
  always_comb begin
    bx_d      = bx_q;
    page_d    = page_q;
    wr_addr_d = wr_addr_q;
    wea_d     = accept_s;
    addra_d   = addra_q;
    pagea_d   = pagea_q;
    dina_d    = dina_q;
    if (clear_s) begin
      bx_d      = bx_in;
      page_d    = page_in_s;
      wr_addr_d = {NENT_W{1'b0}};
    end else if (accept_s) begin
      addra_d   = wr_addr_q[ADDR_W-1:0];
      pagea_d   = page_q;
      dina_d    = bus.din_data;
      wr_addr_d = wr_addr_q + NENT_W'(1'b1);
    end else begin
      wr_addr_d = wr_addr_q;
    end
  end

  // Datapath registers; reset drops any in-flight write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bx_q      <= {BX_W{1'b0}};
      page_q    <= {PAGE_W{1'b0}};
      wr_addr_q <= {NENT_W{1'b0}};
      wea_q     <= 1'b0;
      addra_q   <= {ADDR_W{1'b0}};
      pagea_q   <= {PAGE_W{1'b0}};
      dina_q    <= {RAM_WIDTH{1'b0}};
    end else begin
      bx_q      <= bx_d;
      page_q    <= page_d;
      wr_addr_q <= wr_addr_d;
      wea_q     <= wea_d;
      addra_q   <= addra_d;
      pagea_q   <= pagea_d;
      dina_q    <= dina_d;
    end
  end

  assign bus.din_ready = din_ready_s;
  assign bus.wea       = wea_q;
  assign bus.addra     = addra_q;
  assign bus.pagea     = pagea_q;
  assign bus.dina      = dina_q;
  assign bx_out        = bx_q;

  // Counts advance when the BRAM samples the registered write enable.
  mem_nent_counter #(
    .RAM_DEPTH (RAM_DEPTH),
    .PAGES     (PAGES)
  ) u_nent (
    .clk        (clk),
    .rst        (reset),
    .clr_en_i   (clear_s),
    .clr_page_i (page_in_s),
    .inc_en_i   (wea_q),
    .inc_page_i (pagea_q),
    .nent_o     (nent_o)
  );

`ifdef MEM_WRITER_DROP_CNT_EN
  logic       full_s;
  logic [7:0] drop_q, drop_d;

  assign full_s = (state_q == WR_FULL);

  // Refused-word counter: saturates at 255, restarts with each page.
  always_comb begin
    drop_d = drop_q;
    if (clear_s) begin
      drop_d = 8'd0;
    end else if (full_s && bus.din_valid && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  // Refused-word counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_q <= 8'd0;
    else       drop_q <= drop_d;
  end

  assign dropped_cnt = drop_q;
`else
  assign dropped_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_mem_page_writer.sv
// tb_mem_page_writer: directed table, multi-cycle corner sequences and a
// randomized run, all compared against a transaction-level model of the
// page writer (words used per page, per-page counts, pending commit).
module tb_mem_page_writer;
  import mem_pkg::*;

  localparam int RAM_WIDTH = 32;
  localparam int RAM_DEPTH = 16;
  localparam int PAGES     = 2;
  localparam int BX_W      = 2;
  localparam int NENT_W    = 5;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [BX_W-1:0]         bx_in = '0;
  logic [PAGES*NENT_W-1:0] nent_o;
  logic [BX_W-1:0]         bx_out;
  logic [7:0]              dropped_cnt;

  mem_page_writer_if #(.RAM_WIDTH(RAM_WIDTH), .RAM_DEPTH(RAM_DEPTH), .PAGES(PAGES)) bus ();

  mem_page_writer #(
    .RAM_WIDTH(RAM_WIDTH), .RAM_DEPTH(RAM_DEPTH), .PAGES(PAGES), .BX_W(BX_W)
  ) dut (
    .clk(clk), .reset(reset), .bx_in(bx_in), .bus(bus),
    .nent_o(nent_o), .bx_out(bx_out), .dropped_cnt(dropped_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 = just out of reset, 1 = opening a page, 2 = page open.
  int          m_ph, m_cur_bx, m_used, m_drop, m_pend_pg;
  int          m_cnt [PAGES];
  bit          m_pend;
  bit          e_wea;
  int          e_addra, e_pagea;
  logic [31:0] e_dina;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_cur_bx = 0; m_used = 0; m_drop = 0; m_pend = 1'b0; m_pend_pg = 0;
    for (int p = 0; p < PAGES; p++) m_cnt[p] = 0;
    e_wea = 1'b0; e_addra = 0; e_pagea = 0; e_dina = 32'd0;
  endtask

  function automatic logic [PAGES*NENT_W-1:0] pack_cnt();
    logic [PAGES*NENT_W-1:0] v;
    v = '0;
    for (int p = 0; p < PAGES; p++) v[p*NENT_W +: NENT_W] = NENT_W'(m_cnt[p]);
    return v;
  endfunction

  function automatic int exp_drop();
`ifdef MEM_WRITER_DROP_CNT_EN
    return m_drop;
`else
    return 0;
`endif
  endfunction

  task automatic check_regs();
    chk("wea",         64'(bus.wea),     64'(e_wea));
    chk("addra",       64'(bus.addra),   64'(e_addra));
    chk("pagea",       64'(bus.pagea),   64'(e_pagea));
    chk("dina",        64'(bus.dina),    64'(e_dina));
    chk("nent_o",      64'(nent_o),      64'(pack_cnt()));
    chk("bx_out",      64'(bx_out),      64'(m_cur_bx));
    chk("dropped_cnt", 64'(dropped_cnt), 64'(exp_drop()));
  endtask

  // One clock cycle: drive at the falling edge, check ready, advance the
  // model across the rising edge, check registered outputs just after it.
  task automatic step(input int bx, input bit valid, input logic [31:0] data, output bit rdy_seen);
    bit rdy, acc, was_full;
    bx_in = BX_W'(bx); bus.din_valid = valid; bus.din_data = data;
    #1;
    rdy = (m_ph == 2) && (bx == m_cur_bx) && (m_used < RAM_DEPTH);
    rdy_seen = bus.din_ready;
    chk("din_ready", 64'(bus.din_ready), 64'(rdy));
    acc = rdy && valid;
    was_full = (m_ph == 2) && (m_used == RAM_DEPTH);
    if (m_pend && m_cnt[m_pend_pg] < RAM_DEPTH) m_cnt[m_pend_pg]++;
    m_pend = acc;
    m_pend_pg = m_cur_bx % PAGES;
    e_wea = acc;
    if (acc) begin
      e_addra = m_used; e_pagea = m_cur_bx % PAGES; e_dina = data; m_used++;
    end
    case (m_ph)
      0: m_ph = 1;
      1: begin
        m_cnt[bx % PAGES] = 0; m_cur_bx = bx; m_used = 0; m_drop = 0; m_ph = 2;
      end
      default: begin
        if (was_full && valid && m_drop < 255) m_drop++;
        if (bx != m_cur_bx) m_ph = 1;
      end
    endcase
    @(posedge clk); #1;
    check_regs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.din_valid = 1'b0; bus.din_data = 32'd0; bx_in = '0;
    repeat (2) @(negedge clk);
    model_reset();
    reset = 1'b0;
  endtask

  typedef struct {
    int bx; bit valid; logic [31:0] data;
    bit rdy; bit wea; int addra; int pagea; logic [31:0] dina;
    int n0; int n1; int bxo;
  } vec_t;

  vec_t vt [18];

  initial begin
    bit r;
    int writes, widx;
    bus.din_valid = 1'b0; bus.din_data = 32'd0;
    model_reset();

    // Reset values while reset is held.
    @(negedge clk); #1;
    chk("rst_din_ready", 64'(bus.din_ready), 64'd0);
    check_regs();

    //        bx valid data          rdy wea ad pg dina          n0 n1 bxo
    vt[0]  = '{0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0, 0, 0};
    vt[1]  = '{0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0, 0, 0};
    vt[2]  = '{0, 1, 32'hA000_0000,  1, 1, 0, 0, 32'hA000_0000,  0, 0, 0};
    vt[3]  = '{0, 1, 32'hA000_0001,  1, 1, 1, 0, 32'hA000_0001,  1, 0, 0};
    vt[4]  = '{0, 1, 32'hA000_0002,  1, 1, 2, 0, 32'hA000_0002,  2, 0, 0};
    vt[5]  = '{0, 1, 32'hA000_0003,  1, 1, 3, 0, 32'hA000_0003,  3, 0, 0};
    vt[6]  = '{0, 1, 32'hA000_0004,  1, 1, 4, 0, 32'hA000_0004,  4, 0, 0};
    vt[7]  = '{0, 0, 32'h0,          1, 0, 4, 0, 32'hA000_0004,  5, 0, 0};
    vt[8]  = '{1, 1, 32'hB000_0000,  0, 0, 4, 0, 32'hA000_0004,  5, 0, 0};
    vt[9]  = '{1, 1, 32'hB000_0000,  0, 0, 4, 0, 32'hA000_0004,  5, 0, 1};
    vt[10] = '{1, 1, 32'hB000_0000,  1, 1, 0, 1, 32'hB000_0000,  5, 0, 1};
    vt[11] = '{1, 1, 32'hB000_0001,  1, 1, 1, 1, 32'hB000_0001,  5, 1, 1};
    vt[12] = '{1, 0, 32'h0,          1, 0, 1, 1, 32'hB000_0001,  5, 2, 1};
    vt[13] = '{1, 1, 32'hB000_0002,  1, 1, 2, 1, 32'hB000_0002,  5, 2, 1};
    vt[14] = '{2, 1, 32'hC000_0000,  0, 0, 2, 1, 32'hB000_0002,  5, 3, 1};
    vt[15] = '{2, 1, 32'hC000_0000,  0, 0, 2, 1, 32'hB000_0002,  0, 3, 2};
    vt[16] = '{2, 1, 32'hC000_0000,  1, 1, 0, 0, 32'hC000_0000,  0, 3, 2};
    vt[17] = '{2, 0, 32'h0,          1, 0, 0, 0, 32'hC000_0000,  1, 3, 2};

    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(vt[i].bx, vt[i].valid, vt[i].data, r);
      chk($sformatf("tbl%0d_ready", i), 64'(r),                 64'(vt[i].rdy));
      chk($sformatf("tbl%0d_wea", i),   64'(bus.wea),           64'(vt[i].wea));
      chk($sformatf("tbl%0d_addra", i), 64'(bus.addra),         64'(vt[i].addra));
      chk($sformatf("tbl%0d_pagea", i), 64'(bus.pagea),         64'(vt[i].pagea));
      chk($sformatf("tbl%0d_dina", i),  64'(bus.dina),          64'(vt[i].dina));
      chk($sformatf("tbl%0d_nent0", i), 64'(nent_o[4:0]),       64'(vt[i].n0));
      chk($sformatf("tbl%0d_nent1", i), 64'(nent_o[9:5]),       64'(vt[i].n1));
      chk($sformatf("tbl%0d_bxout", i), 64'(bx_out),            64'(vt[i].bxo));
    end

    // Page overflow: 20 back-to-back words, only 16 land, no wrap to entry 0.
    do_reset();
    step(0, 1'b0, 32'd0, r);
    step(0, 1'b0, 32'd0, r);
    writes = 0; widx = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 1'b1, 32'h5500_0000 + 32'(i), r);
      if (bus.wea) begin
        chk("full_addr_seq", 64'(bus.addra), 64'(widx));
        writes++; widx++;
      end
    end
    step(0, 1'b0, 32'd0, r);
    chk("full_writes", 64'(writes), 64'd16);
    chk("full_ready", 64'(bus.din_ready), 64'd0);
    chk("full_nent0", 64'(nent_o[4:0]), 64'd16);
`ifdef MEM_WRITER_DROP_CNT_EN
    chk("full_dropped", 64'(dropped_cnt), 64'd4);
`else
    chk("full_dropped", 64'(dropped_cnt), 64'd0);
`endif

    // Reset asserted mid-fill at count 9: outputs clear immediately.
    do_reset();
    step(0, 1'b0, 32'd0, r);
    step(0, 1'b0, 32'd0, r);
    for (int i = 0; i < 10; i++) step(0, 1'b1, 32'h7700_0000 + 32'(i), r);
    chk("pre_rst_nent0", 64'(nent_o[4:0]), 64'd9);
    chk("pre_rst_wea", 64'(bus.wea), 64'd1);
    bus.din_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_wea", 64'(bus.wea), 64'd0);
    chk("async_rst_nent", 64'(nent_o), 64'd0);
    chk("async_rst_ready", 64'(bus.din_ready), 64'd0);
    chk("async_rst_addra", 64'(bus.addra), 64'd0);
    chk("async_rst_dina", 64'(bus.dina), 64'd0);
    @(negedge clk);
    model_reset();
    reset = 1'b0;
    step(0, 1'b1, 32'h8800_0000, r);
    chk("post_rst_idle_ready", 64'(r), 64'd0);
    step(0, 1'b1, 32'h8800_0000, r);
    chk("post_rst_clear_ready", 64'(r), 64'd0);
    step(0, 1'b1, 32'h8800_0000, r);
    chk("post_rst_fill_ready", 64'(r), 64'd1);

    // Randomized traffic against the model.
    do_reset();
    begin
      int bx;
      bx = 0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(39, 0) == 0) bx = int'($urandom_range(3, 0));
        step(bx, ($urandom_range(3, 0) != 0), $urandom(), r);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
